// File: rtl/hazard_unit.sv
// Pipeline hazard detection: load-use stall, taken-branch flush and data-memory
// freeze, driven by a shadow copy of the EX/MEM destination/control state.
module hazard_unit #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              branch_taken3,
  input  logic              dmem_ready,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              pipe_freeze,
  output logic              dmem_req,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } entry_t;

  entry_t ex_q, mem_q;
  logic   freeze, flush, lu_stall, rs_hit, rt_hit;

  // MEM-stage destination/reg_write are tracked for completeness but not consumed here.
  logic unused_shadow;
  assign unused_shadow = ^{mem_q.dest, mem_q.reg_write};

  always_comb begin
    dmem_req = mem_q.valid & (mem_q.mem_read | mem_q.mem_write);
    freeze   = dmem_req & ~dmem_ready;
    flush    = branch_taken3 & ~freeze;
    rs_hit   = id_use_rs && (id_rs == ex_q.dest);
    rt_hit   = id_use_rt && (id_rt == ex_q.dest);
    lu_stall = ex_q.valid & ex_q.mem_read & (ex_q.dest != '0) &
               (rs_hit | rt_hit) & ~flush & ~freeze;

    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pipe_freeze = 1'b0;
    if (freeze) begin
      pipe_freeze = 1'b1;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
    end else if (flush) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (lu_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (freeze) begin
        ex_q  <= ex_q;
        mem_q <= mem_q;
      end else if (flush) begin
        ex_q  <= '0;
        mem_q <= '0;
      end else if (lu_stall) begin
        mem_q <= ex_q;
        ex_q  <= '0;
      end else begin
        mem_q <= ex_q;
        ex_q  <= '{1'b1, id_dest, id_reg_write, id_mem_read, id_mem_write};
      end
      if ((freeze || lu_stall) && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a pipeline-occupancy reference model queues
// the expected response per cycle; a monitor pops and compares at negedge.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, id_dest = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0;
  logic       id_reg_write = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
  logic       branch_taken3 = 1'b0, dmem_ready = 1'b1;

  logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_freeze, dmem_req;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_flush, s_exmem_flush, s_pipe_freeze, s_dmem_req;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  hazard_unit #(.CNT_W(16), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_dest(id_dest), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .branch_taken3(branch_taken3),
    .dmem_ready(dmem_ready), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .pipe_freeze(pipe_freeze), .dmem_req(dmem_req), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  hazard_unit #(.CNT_W(4), .REG_AW(5)) dut_small (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_dest(id_dest), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .branch_taken3(branch_taken3),
    .dmem_ready(dmem_ready), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
    .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush),
    .pipe_freeze(s_pipe_freeze), .dmem_req(s_dmem_req), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

  // Reference model: the instructions currently occupying EX and MEM.
  typedef struct {
    bit     valid;
    int     dest;
    bit     ld;
    bit     st;
  } instr_t;

  typedef struct {
    logic [6:0] ctl;   // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_freeze, dmem_req}
    int         stalls;
    int         flushes;
  } exp_t;

  instr_t in_ex, in_mem;
  int     n_stalls = 0, n_flushes = 0;
  exp_t   sb[$];
  exp_t   mon_e;
  int     total = 0, bad = 0;
  bit     m_freeze, m_flush, m_stall;

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, act, expv);
    end
  endtask

  // Decide this cycle's hazard situation from the model, queue the expected
  // response, then advance the model across the clock edge.
  task automatic tick();
    exp_t e;
    bit   req, reads_load;
    req = in_mem.valid && (in_mem.ld || in_mem.st);
    m_freeze = req && !dmem_ready;
    m_flush  = branch_taken3 && !m_freeze;
    reads_load = in_ex.valid && in_ex.ld && in_ex.dest != 0 &&
                 ((id_use_rs && int'(id_rs) == in_ex.dest) || (id_use_rt && int'(id_rt) == in_ex.dest));
    m_stall  = reads_load && !m_flush && !m_freeze;
    if (m_freeze)     e.ctl = 7'b0000011;
    else if (m_flush) e.ctl = {6'b111110, req};
    else if (m_stall) e.ctl = {6'b000100, req};
    else              e.ctl = {6'b110000, req};
    e.stalls  = n_stalls;
    e.flushes = n_flushes;
    sb.push_back(e);
    @(posedge clk);
    if (rst) begin
      in_ex = '{default: 0}; in_mem = '{default: 0};
      n_stalls = 0; n_flushes = 0;
    end else begin
      if (m_freeze || m_stall) n_stalls++;
      if (m_flush) n_flushes++;
      if (m_flush) begin
        in_ex = '{default: 0}; in_mem = '{default: 0};
      end else if (m_stall) begin
        in_mem = in_ex; in_ex = '{default: 0};
      end else if (!m_freeze) begin
        in_mem = in_ex;
        in_ex  = '{1'b1, int'(id_dest), id_mem_read, id_mem_write};
      end
    end
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic [4:0] dst, input logic rw,
                        input logic ld, input logic st);
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_dest = dst; id_reg_write = rw; id_mem_read = ld; id_mem_write = st;
  endtask

  task automatic nop();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle presents one response, checked at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("ctl", int'({pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_freeze, dmem_req}), int'(mon_e.ctl));
        check("ctl_small", int'({s_pc_write, s_ifid_write, s_ifid_flush, s_idex_flush, s_exmem_flush, s_pipe_freeze, s_dmem_req}), int'(mon_e.ctl));
        check("stall_cnt", int'(stall_cnt), sat(mon_e.stalls, 65535));
        check("flush_cnt", int'(flush_cnt), sat(mon_e.flushes, 65535));
        check("stall_cnt_w4", int'(s_stall_cnt), sat(mon_e.stalls, 15));
        check("flush_cnt_w4", int'(s_flush_cnt), sat(mon_e.flushes, 15));
      end
    end
  end

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL timeout: bench did not complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    in_ex = '{default: 0}; in_mem = '{default: 0};
    nop();
    @(posedge clk); #1;
    tick();                       // reset held: shadow empty, normal outputs
    rst = 1'b0;

    // lw r3 ; add r4,r3,r5
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0); tick();
    set_id(5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0); tick(); tick();
    nop(); tick(); tick();

    // lw r0 ; reader of r0, then lw r3 ; use_rs=0 with rs=3
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0); tick();
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0); tick();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0); tick();
    set_id(5'd3, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0); tick();
    nop(); tick(); tick();

    // taken branch flushes an in-flight load; the following reader must not stall
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0); tick();
    set_id(5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    branch_taken3 = 1'b1; tick();
    branch_taken3 = 1'b0; tick();
    nop(); tick(); tick();

    // store reaches MEM, memory not ready for 3 cycles
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1); tick();
    nop(); tick();
    dmem_ready = 1'b0; tick(); tick(); tick();
    dmem_ready = 1'b1; tick(); tick();

    // back-to-back dependent loads saturate the 4-bit counter
    for (int i = 0; i < 22; i++) begin
      set_id(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0); tick(); tick();
    end
    nop(); tick(); tick();

    // reset while frozen
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1); tick();
    nop(); tick();
    dmem_ready = 1'b0; tick(); tick();
    rst = 1'b1; tick();
    rst = 1'b0; dmem_ready = 1'b1; tick(); tick();

    // randomized traffic with a small register range to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      set_id(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
             1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
             1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 2));
      branch_taken3 = ($urandom_range(0, 9) == 0);
      dmem_ready    = ($urandom_range(0, 9) != 0);
      rst           = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; nop(); branch_taken3 = 1'b0; dmem_ready = 1'b1; tick();

    @(negedge clk); @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
